// File: rtl/monopix2_data_emu.sv
// Behavioural emulator of the MONOPIX2 serial data and HITOR outputs, NCH channels.
// Each channel buffers hit words in a FIFO and serialises them MSB first in fixed WORD_W-cycle slots.
module monopix2_data_emu #(
  parameter int                NCH       = 4,
  parameter int                WORD_W    = 32,
  parameter int                DEPTH     = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD = {(WORD_W/2){2'b10}},
  parameter int                HITOR_LEN = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCH-1:0]        EN,
  input  logic [NCH*WORD_W-1:0] HIT_DATA,
  input  logic [NCH-1:0]        HIT_VALID,
  output logic [NCH-1:0]        HIT_READY,
  output logic [NCH-1:0]        DATA_OUT,
  output logic [NCH-1:0]        FRAME_OUT,
  output logic [NCH-1:0]        HITOR_OUT,
  output logic [NCH*8-1:0]      OVF_CNT,
  output logic [NCH-1:0]        FIFO_EMPTY
);

  localparam int              AW           = $clog2(DEPTH);
  localparam int              PW           = AW + 1;
  localparam int              CW           = $clog2(WORD_W);
  localparam logic [CW-1:0]   LAST_BIT     = CW'(WORD_W - 1);
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE      = PW'(1);
  localparam logic [7:0]      HITOR_RELOAD = 8'(HITOR_LEN - 1);

  logic [CW-1:0] bit_cnt_r;
  logic          load_s;

  // Slot counter shared by every channel so all channels stay phase-aligned from reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_r <= {CW{1'b0}};
    end else if (bit_cnt_r == LAST_BIT) begin
      bit_cnt_r <= {CW{1'b0}};
    end else begin
      bit_cnt_r <= bit_cnt_r + CNT_ONE;
    end
  end

  assign load_s = (bit_cnt_r == {CW{1'b0}});

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [PW-1:0]     wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic              push_s, pop_s, drop_s;
    logic              full_nxt_s, empty_nxt_s;
    logic [WORD_W-1:0] shreg_r;
    logic              frame_r, ready_r, empty_r, hitor_r;
    logic [7:0]        ovf_r, hitor_rem_r;

    // Handshake decode and next pointer state; READY is the pre-edge view, so a pop cannot rescue a push.
    always_comb begin
      push_s       = HIT_VALID[ch] & ready_r;
      drop_s       = HIT_VALID[ch] & ~ready_r;
      pop_s        = load_s & EN[ch] & ~empty_r;
      wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      full_nxt_s   = (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]) &&
                     (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
      empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    end

    // FIFO storage; contents are discarded on reset through the pointers alone.
    always_ff @(posedge CLK) begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= HIT_DATA[ch*WORD_W +: WORD_W];
      end
    end

    // Channel state: pointers, flags, serializer, overflow counter and HITOR pulse.
    always_ff @(posedge CLK) begin
      if (RST) begin
        wr_ptr_r    <= {PW{1'b0}};
        rd_ptr_r    <= {PW{1'b0}};
        ready_r     <= 1'b0;
        empty_r     <= 1'b1;
        ovf_r       <= 8'd0;
        shreg_r     <= {WORD_W{1'b0}};
        frame_r     <= 1'b0;
        hitor_r     <= 1'b0;
        hitor_rem_r <= 8'd0;
      end else begin
        wr_ptr_r <= wr_ptr_nxt_s;
        rd_ptr_r <= rd_ptr_nxt_s;
        ready_r  <= ~full_nxt_s;
        empty_r  <= empty_nxt_s;
        if (drop_s && (ovf_r != 8'hFF)) begin
          ovf_r <= ovf_r + 8'd1;
        end
        if (load_s) begin
          shreg_r <= pop_s ? mem_r[rd_ptr_r[AW-1:0]] : IDLE_WORD;
          frame_r <= 1'b1;
        end else begin
          shreg_r <= {shreg_r[WORD_W-2:0], 1'b0};
          frame_r <= 1'b0;
        end
        if (push_s) begin
          hitor_r     <= 1'b1;
          hitor_rem_r <= HITOR_RELOAD;
        end else if (hitor_rem_r != 8'd0) begin
          hitor_r     <= 1'b1;
          hitor_rem_r <= hitor_rem_r - 8'd1;
        end else begin
          hitor_r     <= 1'b0;
        end
      end
    end

    assign HIT_READY[ch]       = ready_r;
    assign FIFO_EMPTY[ch]      = empty_r;
    assign DATA_OUT[ch]        = shreg_r[WORD_W-1];
    assign FRAME_OUT[ch]       = frame_r;
    assign HITOR_OUT[ch]       = hitor_r;
    assign OVF_CNT[ch*8 +: 8]  = ovf_r;
  end

endmodule

// File: tb/tb_monopix2_data_emu.sv
// Directed bench for monopix2_data_emu: table of push/slot vectors plus hand sequences
// for overflow, saturation, EN drop and mid-word reset.
module tb_monopix2_data_emu;

  localparam int          NCH  = 4;
  localparam logic [31:0] IDLE = 32'hAAAAAAAA;

  logic          CLK = 1'b0;
  logic          RST;
  logic [3:0]    EN, HIT_VALID, HIT_READY, DATA_OUT, FRAME_OUT, HITOR_OUT, FIFO_EMPTY;
  logic [127:0]  HIT_DATA;
  logic [31:0]   OVF_CNT;

  always #5 CLK = ~CLK;

  monopix2_data_emu #(.NCH(4), .WORD_W(32), .DEPTH(16), .HITOR_LEN(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .HIT_DATA(HIT_DATA), .HIT_VALID(HIT_VALID),
    .HIT_READY(HIT_READY), .DATA_OUT(DATA_OUT), .FRAME_OUT(FRAME_OUT),
    .HITOR_OUT(HITOR_OUT), .OVF_CNT(OVF_CNT), .FIFO_EMPTY(FIFO_EMPTY)
  );

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          push_at;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t        tbl [6];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cap_w [4];
  logic [31:0] cap_f [4];
  logic [31:0] cap_h [4];
  logic [95:0] got_h, exp_h;
  logic [31:0] exp_w, word_tmp;
  logic [9:0]  got10;
  logic        others_ok;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for the MSB cycle of a slot on channel ach.
  task automatic align(input int ach);
    int n = 0;
    while (!FRAME_OUT[ach] && n < 64) begin
      tick();
      n++;
    end
    check("align_frame", FRAME_OUT[ach], 1'b1);
  endtask

  // Capture one 32-cycle slot on all channels, starting at a frame cycle.
  task automatic run_slot(input int pch, input int push_at, input logic [31:0] pdata, input int drop_at);
    for (int i = 0; i < 32; i++) begin
      for (int c = 0; c < NCH; c++) begin
        cap_w[c][31-i] = DATA_OUT[c];
        cap_f[c][31-i] = FRAME_OUT[c];
        cap_h[c][31-i] = HITOR_OUT[c];
      end
      if (i == push_at) begin
        HIT_DATA[pch*32 +: 32] = pdata;
        HIT_VALID[pch] = 1'b1;
      end
      if (i == drop_at) EN[pch] = 1'b0;
      tick();
      HIT_VALID = 4'b0000;
    end
  endtask

  initial begin
    tbl[0] = '{0, 32'h12345678, 1,  IDLE, 32'h12345678, IDLE};
    tbl[1] = '{1, 32'hCAFEF00D, 30, IDLE, 32'hCAFEF00D, IDLE};
    tbl[2] = '{2, 32'h0F0F0F0F, 31, IDLE, IDLE, 32'h0F0F0F0F};
    tbl[3] = '{3, 32'h80000001, 0,  IDLE, 32'h80000001, IDLE};
    tbl[4] = '{0, 32'hFFFFFFFF, 15, IDLE, 32'hFFFFFFFF, IDLE};
    tbl[5] = '{1, 32'h00000000, 31, IDLE, IDLE, 32'h00000000};

    RST = 1'b1; EN = 4'hF; HIT_VALID = 4'h0; HIT_DATA = 128'd0;
    repeat (3) tick();
    check("rst_data",  DATA_OUT, 4'h0);
    check("rst_frame", FRAME_OUT, 4'h0);
    check("rst_hitor", HITOR_OUT, 4'h0);
    check("rst_ready", HIT_READY, 4'h0);
    check("rst_empty", FIFO_EMPTY, 4'hF);
    check("rst_ovf",   OVF_CNT, 32'h0);

    RST = 1'b0;
    tick();
    check("first_frame", FRAME_OUT, 4'hF);
    check("first_msb",   DATA_OUT, 4'hF);
    check("first_ready", HIT_READY, 4'hF);

    // Table: push one word at a given bit of slot 0, then check three slots.
    for (int t = 0; t < 6; t++) begin
      align(tbl[t].ch);
      for (int s = 0; s < 3; s++) begin
        run_slot(tbl[t].ch, (s == 0) ? tbl[t].push_at : -1, tbl[t].data, -1);
        exp_w = (s == 0) ? tbl[t].exp0 : ((s == 1) ? tbl[t].exp1 : tbl[t].exp2);
        check($sformatf("tbl%0d_slot%0d_word", t, s), cap_w[tbl[t].ch], exp_w);
        check($sformatf("tbl%0d_slot%0d_frame", t, s), cap_f[tbl[t].ch], 32'h80000000);
        others_ok = 1'b1;
        for (int c = 0; c < NCH; c++)
          if (c != tbl[t].ch && cap_w[c] !== IDLE) others_ok = 1'b0;
        check($sformatf("tbl%0d_slot%0d_others_idle", t, s), others_ok, 1'b1);
        got_h[95-32*s -: 32] = cap_h[tbl[t].ch];
      end
      for (int g = 0; g < 96; g++)
        exp_h[95-g] = (g > tbl[t].push_at) && (g <= tbl[t].push_at + 4);
      check($sformatf("tbl%0d_hitor", t), got_h, exp_h);
    end
    check("tbl_ovf", OVF_CNT, 32'h0);

    // Overflow with EN low: 20 pushes into a 16-deep FIFO.
    EN[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      HIT_DATA[96 +: 32] = 32'h30000000 + k;
      HIT_VALID[3] = 1'b1;
      tick();
    end
    HIT_VALID = 4'h0;
    check("ovf20_cnt",   OVF_CNT[31:24], 8'd4);
    check("ovf20_ready", HIT_READY[3], 1'b0);
    check("ovf20_empty", FIFO_EMPTY[3], 1'b0);
    align(3);
    EN[3] = 1'b1;
    // Push on the load edge while full: pop happens, push still rejected.
    run_slot(3, 31, 32'hDEAD0000, -1);
    check("full_pop_idle",  cap_w[3], IDLE);
    check("full_pop_ovf",   OVF_CNT[31:24], 8'd5);
    check("full_pop_ready", HIT_READY[3], 1'b1);
    check("full_pop_hitor", HITOR_OUT[3], 1'b0);
    for (int k = 0; k < 16; k++) begin
      run_slot(3, -1, 32'h0, -1);
      check($sformatf("drain%0d", k), cap_w[3], 32'h30000000 + k);
    end
    run_slot(3, -1, 32'h0, -1);
    check("drain_idle",  cap_w[3], IDLE);
    check("drain_empty", FIFO_EMPTY[3], 1'b1);

    // EN falling mid-word on ch0.
    run_slot(0, 30, 32'h11111111, -1);
    check("en_pre_idle", cap_w[0], IDLE);
    run_slot(0, 5, 32'h22222222, 10);
    check("en_drop_word", cap_w[0], 32'h11111111);
    run_slot(0, 3, 32'h33333333, -1);
    check("en_off_idle",  cap_w[0], IDLE);
    check("en_off_empty", FIFO_EMPTY[0], 1'b0);
    check("en_off_ovf",   OVF_CNT[7:0], 8'd0);
    EN[0] = 1'b1;
    run_slot(0, -1, 32'h0, -1);
    check("en_on_idle", cap_w[0], IDLE);
    run_slot(0, -1, 32'h0, -1);
    check("en_on_b", cap_w[0], 32'h22222222);
    run_slot(0, -1, 32'h0, -1);
    check("en_on_c", cap_w[0], 32'h33333333);
    run_slot(0, -1, 32'h0, -1);
    check("en_on_tail", cap_w[0], IDLE);
    check("en_on_empty", FIFO_EMPTY[0], 1'b1);

    // Saturation on ch3: 16 accepted, then drops from ovf=5 upward.
    EN[3] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      HIT_DATA[96 +: 32] = 32'h31000000 + k;
      HIT_VALID[3] = 1'b1;
      tick();
    end
    check("sat_mid", OVF_CNT[31:24], 8'd245);
    for (int k = 0; k < 60; k++) tick();
    HIT_VALID = 4'h0;
    check("sat_end", OVF_CNT[31:24], 8'd255);

    // Reset at bit 10 of a data word with words queued.
    align(3);
    EN[3] = 1'b1;
    run_slot(3, -1, 32'h0, -1);
    check("pre_rst_idle", cap_w[3], IDLE);
    for (int i = 0; i < 10; i++) begin
      got10[9-i] = DATA_OUT[3];
      tick();
    end
    word_tmp = 32'h31000000;
    check("pre_rst_bits", got10, word_tmp[31:22]);
    RST = 1'b1;
    tick();
    check("mid_rst_data",  DATA_OUT, 4'h0);
    check("mid_rst_frame", FRAME_OUT, 4'h0);
    check("mid_rst_hitor", HITOR_OUT, 4'h0);
    check("mid_rst_ready", HIT_READY, 4'h0);
    check("mid_rst_empty", FIFO_EMPTY, 4'hF);
    check("mid_rst_ovf",   OVF_CNT, 32'h0);
    RST = 1'b0;
    tick();
    check("post_rst_frame", FRAME_OUT, 4'hF);
    check("post_rst_msb",   DATA_OUT, 4'hF);
    for (int s = 0; s < 2; s++) begin
      run_slot(3, -1, 32'h0, -1);
      others_ok = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (cap_w[c] !== IDLE) others_ok = 1'b0;
      check($sformatf("post_rst_idle%0d", s), others_ok, 1'b1);
    end
    check("post_rst_empty", FIFO_EMPTY, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
